// File: rtl/alarm_time_setter.sv
// Button-driven editor for the alarm compare registers, with arm/disarm flag.
// Optional BUTTON_DEBOUNCE_EN adds a per-button stability filter after the synchroniser.
module alarm_time_setter #(
    parameter int FIELD_W         = 2,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_mode,
    input  logic               btn_inc,
    input  logic               btn_set,
    output logic [FIELD_W-1:0] alarm_hours,
    output logic [FIELD_W-1:0] alarm_minutes,
    output logic [FIELD_W-1:0] alarm_seconds,
    output logic               alarm_armed,
    output logic               cfg_update,
    output logic               edit_active,
    output logic [1:0]         edit_field,
    output logic [FIELD_W-1:0] edit_value
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, EDIT_S} state_t;

    // bit 2 = set, bit 1 = mode, bit 0 = inc
    logic [2:0] sync1, sync2, level, prev, rise;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {btn_set, btn_mode, btn_inc};
            sync2 <= sync1;
            prev  <= level;
        end
    end

`ifdef BUTTON_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [DW-1:0] cnt;

        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt      <= '0;
                level[i] <= 1'b0;
            end else if (sync2[i] == level[i]) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                cnt      <= '0;
                level[i] <= sync2[i];
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end
`else
    assign level = sync2;
`endif

    assign rise = level & ~prev;

    logic ev_set, ev_mode, ev_inc;

    assign ev_set  = rise[2];
    assign ev_mode = rise[1] & ~rise[2];
    assign ev_inc  = rise[0] & ~rise[1] & ~rise[2];

    state_t             state, state_n;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic [FIELD_W-1:0] sh_h, sh_m, sh_s;
    logic [FIELD_W-1:0] sh_h_n, sh_m_n, sh_s_n;
    logic [FIELD_W-1:0] hours_n, minutes_n, seconds_n;
    logic               armed_n, commit;
    logic [1:0]         field_n;
    logic [FIELD_W-1:0] value_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            tcnt          <= '0;
            sh_h          <= '0;
            sh_m          <= '0;
            sh_s          <= '0;
            alarm_hours   <= '0;
            alarm_minutes <= '0;
            alarm_seconds <= '0;
            alarm_armed   <= 1'b0;
            cfg_update    <= 1'b0;
            edit_active   <= 1'b0;
            edit_field    <= 2'd0;
            edit_value    <= '0;
        end else begin
            state         <= state_n;
            tcnt          <= tcnt_n;
            sh_h          <= sh_h_n;
            sh_m          <= sh_m_n;
            sh_s          <= sh_s_n;
            alarm_hours   <= hours_n;
            alarm_minutes <= minutes_n;
            alarm_seconds <= seconds_n;
            alarm_armed   <= armed_n;
            cfg_update    <= commit;
            edit_active   <= (state_n != IDLE);
            edit_field    <= field_n;
            edit_value    <= value_n;
        end
    end

    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt;
        sh_h_n    = sh_h;
        sh_m_n    = sh_m;
        sh_s_n    = sh_s;
        hours_n   = alarm_hours;
        minutes_n = alarm_minutes;
        seconds_n = alarm_seconds;
        armed_n   = alarm_armed;
        commit    = 1'b0;

        unique case (state)
            IDLE: begin
                tcnt_n = '0;
                if (ev_set) begin
                    armed_n = ~alarm_armed;
                end else if (ev_mode) begin
                    state_n = EDIT_H;
                    sh_h_n  = alarm_hours;
                    sh_m_n  = alarm_minutes;
                    sh_s_n  = alarm_seconds;
                end
            end
            default: begin
                if (ev_set) begin
                    state_n   = IDLE;
                    tcnt_n    = '0;
                    hours_n   = sh_h;
                    minutes_n = sh_m;
                    seconds_n = sh_s;
                    armed_n   = 1'b1;
                    commit    = 1'b1;
                end else if (ev_mode) begin
                    tcnt_n = '0;
                    unique case (state)
                        EDIT_H:  state_n = EDIT_M;
                        EDIT_M:  state_n = EDIT_S;
                        default: state_n = EDIT_H;
                    endcase
                end else if (ev_inc) begin
                    tcnt_n = '0;
                    unique case (state)
                        EDIT_H:  sh_h_n = sh_h + FIELD_W'(1);
                        EDIT_M:  sh_m_n = sh_m + FIELD_W'(1);
                        default: sh_s_n = sh_s + FIELD_W'(1);
                    endcase
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    // abandoned edit: committed values and arm flag untouched
                    state_n = IDLE;
                    tcnt_n  = '0;
                    sh_h_n  = '0;
                    sh_m_n  = '0;
                    sh_s_n  = '0;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
        endcase
    end

    always_comb begin
        field_n = 2'd0;
        value_n = '0;
        unique case (state_n)
            EDIT_H: begin
                field_n = 2'd1;
                value_n = sh_h_n;
            end
            EDIT_M: begin
                field_n = 2'd2;
                value_n = sh_m_n;
            end
            EDIT_S: begin
                field_n = 2'd3;
                value_n = sh_s_n;
            end
            default: begin
                field_n = 2'd0;
                value_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_alarm_time_setter.sv
// Directed self-checking bench for alarm_time_setter.
// Build with BUTTON_DEBOUNCE_EN to also exercise the glitch filter.
module tb_alarm_time_setter;

`ifdef BUTTON_DEBOUNCE_EN
    localparam int HOLD = 8;
    localparam int LOW  = 8;
`else
    localparam int HOLD = 3;
    localparam int LOW  = 4;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_set = 1'b0;
    logic [1:0] alarm_hours, alarm_minutes, alarm_seconds;
    logic       alarm_armed, cfg_update, edit_active;
    logic [1:0] edit_field;
    logic [1:0] edit_value;

    int n_cmp = 0;
    int n_bad = 0;
    int cfg_total = 0;
    int c0;

    alarm_time_setter dut (
        .clk(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .btn_set(btn_set),
        .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_seconds(alarm_seconds),
        .alarm_armed(alarm_armed),
        .cfg_update(cfg_update),
        .edit_active(edit_active),
        .edit_field(edit_field),
        .edit_value(edit_value)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cfg_update) cfg_total++;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // mask bits: 2 = set, 1 = mode, 0 = inc
    task automatic press(input logic [2:0] m, input int hold);
        @(negedge clk);
        {btn_set, btn_mode, btn_inc} = m;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        {btn_set, btn_mode, btn_inc} = 3'b000;
        repeat (LOW) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_alarm(input string tag, input int h, input int m, input int s);
        check({tag, "_h"}, alarm_hours, h);
        check({tag, "_m"}, alarm_minutes, m);
        check({tag, "_s"}, alarm_seconds, s);
    endtask

    initial begin
        // reset with all buttons pressed
        btn_mode = 1'b1; btn_inc = 1'b1; btn_set = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_alarm("rst", 0, 0, 0);
        check("rst_armed", alarm_armed, 0);
        check("rst_cfg", cfg_update, 0);
        check("rst_active", edit_active, 0);
        check("rst_field", edit_field, 0);
        check("rst_value", edit_value, 0);
        reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_set = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("rel_active", edit_active, 0);
        check("rel_armed", alarm_armed, 0);
        check("rel_cfg_cnt", cfg_total, 0);

        // full edit and commit
        press(3'b010, HOLD);
        check("e_active", edit_active, 1);
        check("e_field_h", edit_field, 1);
        check("e_val_h0", edit_value, 0);
        press(3'b001, HOLD);
        press(3'b001, HOLD);
        check("e_val_h2", edit_value, 2);
        press(3'b010, HOLD);
        check("e_field_m", edit_field, 2);
        check("e_val_m0", edit_value, 0);
        repeat (3) press(3'b001, HOLD);
        check("e_val_m3", edit_value, 3);
        press(3'b010, HOLD);
        check("e_field_s", edit_field, 3);
        press(3'b001, HOLD);
        check("e_val_s1", edit_value, 1);
        check("e_hold_h", alarm_hours, 0);
        c0 = cfg_total;
        press(3'b100, HOLD);
        check_alarm("commit1", 2, 3, 1);
        check("commit1_cfg", cfg_total - c0, 1);
        check("commit1_armed", alarm_armed, 1);
        check("commit1_field", edit_field, 0);
        check("commit1_active", edit_active, 0);
        check("commit1_value", edit_value, 0);

        // hours to 3, then wrap in edit
        press(3'b010, HOLD);
        check("w_load", edit_value, 2);
        press(3'b001, HOLD);
        press(3'b100, HOLD);
        check("w_h3", alarm_hours, 3);
        press(3'b010, HOLD);
        check("w_load3", edit_value, 3);
        press(3'b001, HOLD);
        check("w_wrap", edit_value, 0);
        check("w_stable", alarm_hours, 3);
        c0 = cfg_total;
        press(3'b100, HOLD);
        check_alarm("commit2", 0, 3, 1);
        check("commit2_cfg", cfg_total - c0, 1);

        // timeout abandons the edit
        c0 = cfg_total;
        press(3'b010, HOLD);
        check("to_enter", edit_active, 1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("to_still", edit_active, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("to_idle", edit_active, 0);
        check("to_field", edit_field, 0);
        check("to_value", edit_value, 0);
        check_alarm("to", 0, 3, 1);
        check("to_armed", alarm_armed, 1);
        check("to_cfg", cfg_total - c0, 0);

        // arm toggling in IDLE, priorities in EDIT
        press(3'b100, HOLD);
        check("arm_t1", alarm_armed, 0);
        press(3'b100, HOLD);
        check("arm_t2", alarm_armed, 1);
        press(3'b010, HOLD);
        check("p_load", edit_value, 0);
        press(3'b011, HOLD);
        check("p_mi_field", edit_field, 2);
        check("p_mi_value", edit_value, 3);
        press(3'b010, HOLD);
        check("p_s_value", edit_value, 1);
        press(3'b010, HOLD);
        check("p_h_field", edit_field, 1);
        check("p_h_noinc", edit_value, 0);
        press(3'b001, 12);
        check("p_held_once", edit_value, 1);
        c0 = cfg_total;
        press(3'b110, HOLD);
        check("p_sm_active", edit_active, 0);
        check_alarm("p_sm", 1, 3, 1);
        check("p_sm_cfg", cfg_total - c0, 1);

        // commit re-arms a disarmed alarm
        press(3'b100, HOLD);
        check("rearm_off", alarm_armed, 0);
        press(3'b010, HOLD);
        press(3'b100, HOLD);
        check("rearm_on", alarm_armed, 1);
        check_alarm("rearm", 1, 3, 1);

`ifdef BUTTON_DEBOUNCE_EN
        press(3'b010, HOLD);
        check("db_load", edit_value, 1);
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        btn_inc = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("db_glitch", edit_value, 1);
        press(3'b001, 10);
        check("db_press", edit_value, 2);
        press(3'b100, HOLD);
        check("db_commit", alarm_hours, 2);
`endif

        // reset mid-run clears everything
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_alarm("rst2", 0, 0, 0);
        check("rst2_armed", alarm_armed, 0);
        check("rst2_active", edit_active, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
